iroot_seq: RTL
==============

# iroot_seq

Parametrised sequential integer root unit. Computes floor square root or floor cube root of a WIDTH-bit unsigned operand, selected per operation, using a digit-by-digit restoring algorithm. It is the generalised successor of the fixed 8-bit cube-root unit and keeps the same start/busy handshake. It also adds a completion pulse and an optional remainder output.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- RW, (WIDTH+1)/2, result width; derived, do not override.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- mode  in  1  0 = square root, 1 = cube root; sampled on accept.
- a  in  WIDTH  unsigned operand; sampled on accept.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE cycle.
- res  out  RW  floor(a^(1/k)), where k = 2 or 3.
- rem  out  WIDTH  a − res^k; present per Configuration.

## Operation
- Latched on accept:
  - x ← a; y ← 0; k ← mode ? 3 : 2.
  - N ← ceil(WIDTH/k) iterations; s ← k·(N−1).
- States: IDLE, CALC, STEP, DONE.
- IDLE to CALC when start=1.
- CALC:
  - y ← 2y.
  - b ← ((2y+1)^k − (2y)^k) << s, which is (4y+1)<<s for square root and (12y²+6y+1)<<s for cube root.
  - Go to STEP.
- STEP:
  - If x ≥ b: x ← x − b and y ← y + 1.
  - Then s ← s − k.
  - Return to CALC while iterations remain; after the N-th STEP, go to DONE.
- DONE:
  - res ← y; rem ← x; done=1.
  - Go to IDLE.
- Arithmetic: b and the compare are evaluated at 2·WIDTH+2 bits so the shifted term never truncates. x never goes negative. The final x fits in WIDTH bits.
- res and rem are registered outputs. They change only in DONE and otherwise hold the last result.
- start while busy=1, including the DONE cycle, is ignored and not queued. a and mode may change freely after accept.

## Timing
- Reset values: state IDLE, busy=0, done=0, res=0, rem=0, internal x/y/s=0.
- Accept edge: start=1 in IDLE at edge T.
- busy=1 from T+1. CALC/STEP occupy 2N cycles; DONE occurs in cycle T+2N+1 with done=1 and the new res/rem visible.
- busy=0 from T+2N+2. A new start may be sampled at the edge that leaves DONE only if IDLE; the earliest accept is edge T+2N+2.
- Total busy length is 2N+1 cycles:
  - WIDTH=8: cube N=3 → 7 cycles; square N=4 → 9 cycles.
  - WIDTH=16: cube N=6 → 13 cycles; square N=8 → 17 cycles.
- Reset asserted mid-operation aborts immediately. No done pulse; outputs return to reset values.
- a=0 gives the full latency with res=0 and rem=0. There is no early exit; latency depends only on mode and WIDTH.

## Configuration
- IROOT_REM_EN defined:
  - Remainder register is built.
  - rem = a − res^k, loaded in DONE.
- IROOT_REM_EN undefined:
  - No remainder register.
  - rem is tied to 0 at all times.
  - res and timing are unchanged.

## Test plan
- WIDTH=8, mode=1, a=27 → done in cycle T+7, res=3, rem=0; busy high exactly 7 cycles.
- WIDTH=8, mode=1, a=255 → res=6, rem=39. Same WIDTH, mode=0, a=255 → res=15, rem=30, busy high 9 cycles.
- WIDTH=8, exhaustive sweep of a=0..255 in both modes → res^k ≤ a < (res+1)^k and rem = a − res^k for every value. With IROOT_REM_EN off, rem=0 throughout.
- WIDTH=16, a=65535:
  - mode=1 → res=40, rem=1535 after 13 busy cycles.
  - mode=0 → res=255, rem=510 after 17 busy cycles.
- start pulsed again mid-operation with a different a → ignored; the first result is delivered unchanged and there is exactly one done pulse.
- rst asserted in the 4th busy cycle → busy, done, res and rem are 0 immediately. A subsequent start with a=8, mode=1 gives res=2, rem=0.

Source files
------------

// File: rtl/iroot_seq_if.sv
// Request/response bundle for iroot_seq: start/mode/operand in, busy/done/result out.
interface iroot_seq_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned RW = (WIDTH + 1) / 2;

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [RW-1:0]    res;
  logic [WIDTH-1:0] rem;

  modport master (output start, mode, a, input busy, done, res, rem);
  modport slave  (input start, mode, a, output busy, done, res, rem);
endinterface

// File: rtl/iroot_seq.sv
// iroot_seq: sequential floor square/cube root, digit-by-digit restoring.
// One result digit per CALC/STEP pair; latency depends only on mode and WIDTH.
// Optional feature macro: IROOT_REM_EN builds the remainder register;
// without it rem is tied to zero.
module iroot_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  iroot_seq_if.slave  bus
);
  localparam int unsigned RW   = (WIDTH + 1) / 2;
  localparam int unsigned BW   = 2 * WIDTH + 2;
  localparam int unsigned SW   = $clog2(WIDTH + 1);
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned N_SQ = (WIDTH + 1) / 2;
  localparam int unsigned N_CB = (WIDTH + 2) / 3;
  localparam int unsigned S_SQ = 2 * (N_SQ - 1);
  localparam int unsigned S_CB = 3 * (N_CB - 1);

  typedef enum logic [1:0] {IDLE, CALC, STEP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q;
  logic [RW-1:0]    y_q;
  logic [SW-1:0]    s_q;
  logic [CW-1:0]    cnt_q;
  logic             cube_q;
  logic [BW-1:0]    b_q;
  logic             busy_q, done_q;
  logic [RW-1:0]    res_q;

  logic [BW-1:0]    y_ext_c, b_c;
  logic [WIDTH-1:0] x_step_c;
  logic [RW-1:0]    y_step_c;
  logic             last_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    state_d = STEP;
      STEP:    state_d = (cnt_q == CW'(1)) ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Trial subtrahend from the pre-doubling y, and the conditional subtract
  always_comb begin
    y_ext_c  = BW'(y_q);
    b_c      = '0;
    x_step_c = x_q;
    y_step_c = y_q;
    if (cube_q) b_c = (BW'(12) * y_ext_c * y_ext_c + BW'(6) * y_ext_c + BW'(1)) << s_q;
    else        b_c = (BW'(4) * y_ext_c + BW'(1)) << s_q;
    if (BW'(x_q) >= b_q) begin
      x_step_c = WIDTH'(BW'(x_q) - b_q);
      y_step_c = y_q + RW'(1);
    end
  end

  assign last_c = (state_q == STEP) && (cnt_q == CW'(1));

  // Datapath, handshake flags and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      cube_q <= 1'b0;
      b_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      case (state_q)
        IDLE: if (bus.start) begin
          x_q    <= bus.a;
          y_q    <= '0;
          cube_q <= bus.mode;
          s_q    <= bus.mode ? SW'(S_CB) : SW'(S_SQ);
          cnt_q  <= bus.mode ? CW'(N_CB) : CW'(N_SQ);
        end
        CALC: begin
          b_q <= b_c;
          y_q <= y_q << 1;
        end
        STEP: begin
          x_q   <= x_step_c;
          y_q   <= y_step_c;
          s_q   <= s_q - (cube_q ? SW'(3) : SW'(2));
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
      if (last_c) res_q <= y_step_c;
    end
  end

`ifdef IROOT_REM_EN
  logic [WIDTH-1:0] rem_q;

  // Remainder register, loaded alongside the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rem_q <= '0;
    else if (last_c) rem_q <= x_step_c;
  end

  assign bus.rem = rem_q;
`else
  assign bus.rem = '0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
endmodule
